// File: rtl/myCPU_pkg.sv
// Shared constants for the MIPS register-file slice.
//   DATA_WIDTH / ADDR_WIDTH : default register width and index width
//   REG_ZERO                : hard-wired zero register index
//   INIT / RUN              : clear-FSM state encoding
package myCPU_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int REG_ZERO   = 0;

    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard used by decode for RAW hazard detection.
//   clk, rst          : clock, synchronous active-high reset (clears all busy bits)
//   clr_en, clr_addr  : writeback retired a producer; clear its busy bit
//   set_en, set_addr  : decode issued a producer; set its busy bit
//   raddr             : packed read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rbusy             : per-port busy flag, masked by same-cycle clear and r0
// The parent gates clr_en/set_en with RUN and a non-zero index.
module regfile_scoreboard #(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr_en,
    input  logic [ADDR_WIDTH-1:0]          clr_addr,
    input  logic                           set_en,
    input  logic [ADDR_WIDTH-1:0]          set_addr,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_READ-1:0]            rbusy
);
    import myCPU_pkg::*;

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0] busy;

    // Set is applied after clear so a new producer issued in the same
    // cycle as the old one retires leaves the register busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (clr_en) busy[clr_addr] <= 1'b0;
            if (set_en) busy[set_addr] <= 1'b1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_READ; g++) begin : g_port
            logic [ADDR_WIDTH-1:0] ra;
            assign ra = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];
            // A value being bypassed from writeback this cycle is ready.
            assign rbusy[g] = busy[ra] & ~(clr_en && (clr_addr == ra))
                              & (ra != ADDR_WIDTH'(REG_ZERO));
        end
    endgenerate

endmodule

// File: rtl/regfile_mp_bypass.sv
// Multi-read-port MIPS register file with write-to-read bypass, busy
// scoreboard and a post-reset clear sequence.
//   clk, rst            : clock, synchronous active-high reset
//   wen, waddr, wdata   : writeback write port
//   raddr, rdata        : NUM_READ packed combinational read ports
//   rbusy               : per-port outstanding-producer flag
//   set_busy, set_addr  : decode marks a destination busy
//   init_done           : clear sequence complete (RUN state)
module regfile_mp_bypass #(
    parameter int DATA_WIDTH = myCPU_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = myCPU_pkg::ADDR_WIDTH,
    parameter int NUM_READ   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wen,
    input  logic [ADDR_WIDTH-1:0]          waddr,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
    output logic [NUM_READ-1:0]            rbusy,
    input  logic                           set_busy,
    input  logic [ADDR_WIDTH-1:0]          set_addr,
    output logic                           init_done
);
    import myCPU_pkg::*;

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rf [DEPTH];
    logic [0:0]            state;
    // One extra bit so the counter cannot wrap before the terminal compare.
    logic [ADDR_WIDTH:0]   cnt;
    logic                  run;
    logic                  wr_ok;
    logic                  set_ok;

    assign run       = (state == RUN);
    assign init_done = run;
    assign wr_ok     = run && wen      && (waddr    != ADDR_WIDTH'(REG_ZERO));
    assign set_ok    = run && set_busy && (set_addr != ADDR_WIDTH'(REG_ZERO));

    // Clear FSM: one register zeroed per cycle, RUN on the edge that
    // zeroes the last entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == (ADDR_WIDTH+1)'(DEPTH-1)) state <= RUN;
        end
    end

    // Storage has no reset of its own; the clear sequence owns its contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT)
                rf[cnt[ADDR_WIDTH-1:0]] <= '0;
            else if (wr_ok)
                rf[waddr] <= wdata;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_READ; g++) begin : g_rd
            logic [ADDR_WIDTH-1:0] ra;
            assign ra = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];
            // Contents are undefined until cleared, so INIT forces zero.
            assign rdata[g*DATA_WIDTH +: DATA_WIDTH] =
                (!run || ra == ADDR_WIDTH'(REG_ZERO)) ? '0 :
                (wen && waddr == ra)                   ? wdata :
                                                         rf[ra];
        end
    endgenerate

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_READ   (NUM_READ)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .clr_en   (wr_ok),
        .clr_addr (waddr),
        .set_en   (set_ok),
        .set_addr (set_addr),
        .raddr    (raddr),
        .rbusy    (rbusy)
    );

endmodule

// File: tb/tb_regfile_mp_bypass.sv
module tb_regfile_mp_bypass;
    localparam int DW = 32, AW = 5, NR = 3, DEPTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, wen, set_busy, init_done;
    logic [AW-1:0]     waddr, set_addr;
    logic [DW-1:0]     wdata;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rbusy;

    regfile_mp_bypass #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .set_busy(set_busy), .set_addr(set_addr), .init_done(init_done)
    );

    // Reference model: register values, busy flags, cycles left in clear.
    logic [DW-1:0] m_rf [DEPTH];
    bit            m_busy [DEPTH];
    int            m_left;
    bit            m_valid = 0;

    int nvec = 0, nerr = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int port_addr(int p);
        logic [NR*AW-1:0] r;
        r = raddr;
        return int'(r[p*AW +: AW]);
    endfunction

    function automatic logic [DW-1:0] m_read(int a);
        if (m_left != 0 || a == 0) return '0;
        if (wen && int'(waddr) == a) return wdata;
        return m_rf[a];
    endfunction

    function automatic bit m_rbusy(int a);
        if (m_left != 0 || a == 0) return 0;
        if (wen && int'(waddr) == a) return 0;
        return m_busy[a];
    endfunction

    // Inputs are stable from the negedge; check outputs, then advance one edge.
    task automatic cycle();
        logic [NR*DW-1:0] er;
        logic [NR-1:0]    eb;
        #1;
        if (m_valid) begin
            for (int p = 0; p < NR; p++) begin
                er[p*DW +: DW] = m_read(port_addr(p));
                eb[p]          = m_rbusy(port_addr(p));
            end
            chk("init_done", 128'(init_done), 128'(m_left == 0));
            chk("rdata",     128'(rdata),     128'(er));
            chk("rbusy",     128'(rbusy),     128'(eb));
        end
        @(posedge clk);
        if (rst) begin
            m_valid = 1;
            m_left  = DEPTH;
            for (int i = 0; i < DEPTH; i++) begin m_rf[i] = '0; m_busy[i] = 0; end
        end else if (m_valid) begin
            if (m_left != 0) m_left--;
            else begin
                if (wen && waddr != 0) begin m_rf[waddr] = wdata; m_busy[waddr] = 0; end
                if (set_busy && set_addr != 0) m_busy[set_addr] = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; wen = 0; waddr = '0; wdata = '0; set_busy = 0; set_addr = '0; raddr = '0;
    endtask

    task automatic rd3(input int a0, input int a1, input int a2);
        raddr = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        wen = 1; waddr = AW'(a); wdata = d;
    endtask

    initial begin
        idle();
        rst = 1;
        @(negedge clk);
        // 1. reset and clear, write during INIT dropped
        cycle(); cycle();
        rst = 0;
        for (int c = 0; c < DEPTH; c++) begin
            idle();
            rd3($urandom_range(0, 31), $urandom_range(0, 31), 3);
            if (c == 5) begin wr(3, 32'hDEAD); set_busy = 1; set_addr = 5'd3; end
            cycle();
        end
        idle(); rd3(3, 1, 31); #1;
        chk("tp1_done", 128'(init_done), 128'(1));
        chk("tp1_r3", 128'(rdata[0 +: DW]), 128'(0));
        chk("tp1_busy", 128'(rbusy), 128'(0));
        cycle();

        // 2. basic write/read, r0 write dropped
        idle(); wr(7, 32'h12345678); cycle();
        idle(); rd3(7, 0, 7); #1;
        chk("tp2_read", 128'(rdata), 128'({32'h12345678, 32'h0, 32'h12345678}));
        cycle();
        idle(); wr(0, 32'hFFFFFFFF); cycle();
        idle(); rd3(0, 0, 0); #1;
        chk("tp2_r0", 128'(rdata), 128'(0));
        cycle();

        // 3. bypass
        idle(); wr(9, 32'h1); cycle();
        idle(); wr(9, 32'hABCD); rd3(9, 9, 9); #1;
        chk("tp3_bypass", 128'(rdata[0 +: DW]), 128'(32'hABCD));
        cycle();
        idle(); rd3(9, 0, 0); #1;
        chk("tp3_after", 128'(rdata[0 +: DW]), 128'(32'hABCD));
        cycle();

        // 4. scoreboard set then clear with bypassed read
        idle(); set_busy = 1; set_addr = 5'd4; cycle();
        idle(); rd3(4, 0, 0); #1;
        chk("tp4_busy", 128'(rbusy[0]), 128'(1));
        cycle();
        idle(); rd3(4, 0, 0); wr(4, 32'h44); #1;
        chk("tp4_byp_busy", 128'(rbusy[0]), 128'(0));
        chk("tp4_byp_data", 128'(rdata[0 +: DW]), 128'(32'h44));
        cycle();
        idle(); rd3(4, 0, 0); #1;
        chk("tp4_cleared", 128'(rbusy[0]), 128'(0));
        cycle();

        // 5. set/clear collision, r0 never busy
        idle(); set_busy = 1; set_addr = 5'd6; cycle();
        idle(); wr(6, 32'h66); set_busy = 1; set_addr = 5'd6; cycle();
        idle(); rd3(6, 0, 0); #1;
        chk("tp5_collide", 128'(rbusy[0]), 128'(1));
        cycle();
        idle(); set_busy = 1; set_addr = 5'd0; cycle();
        idle(); rd3(0, 0, 0); #1;
        chk("tp5_r0", 128'(rbusy), 128'(0));
        cycle();

        // 6. reset mid-run
        idle(); wr(5, 32'h55); cycle();
        idle(); set_busy = 1; set_addr = 5'd5; cycle();
        idle(); rst = 1; cycle();
        idle();
        for (int c = 0; c < DEPTH; c++) begin rd3(5, 6, 7); cycle(); end
        rd3(5, 6, 7); #1;
        chk("tp6_done", 128'(init_done), 128'(1));
        chk("tp6_r5", 128'(rdata[0 +: DW]), 128'(0));
        chk("tp6_busy", 128'(rbusy), 128'(0));
        cycle();

        // Random traffic, narrow index range half the time to force collisions
        for (int c = 0; c < 2000; c++) begin
            bit narrow;
            narrow   = ($urandom_range(0, 1) == 1);
            rst      = ($urandom_range(0, 399) == 0);
            wen      = ($urandom_range(0, 1) == 1);
            waddr    = AW'(narrow ? $urandom_range(0, 7) : $urandom_range(0, 31));
            wdata    = $urandom;
            set_busy = ($urandom_range(0, 2) == 0);
            set_addr = AW'(narrow ? $urandom_range(0, 7) : $urandom_range(0, 31));
            for (int p = 0; p < NR; p++)
                raddr[p*AW +: AW] = AW'(narrow ? $urandom_range(0, 7) : $urandom_range(0, 31));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/regfile_mp_bypass.md
Name: regfile_mp_bypass

Overview:
Parametrised successor to the single-write, dual-read MIPS register file. It adds:
- NUM_READ combinational read ports with same-cycle write-to-read bypass.
- A per-register busy scoreboard, so the decode stage can detect RAW hazards.
- A sequential clear FSM that zeroes every register after reset.

It sits between decode (reads, busy set) and writeback (write, busy clear) in the 5-stage pipeline.

Parameters:
DATA_WIDTH, 32, register width in bits
ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH entries
NUM_READ, 2, number of read ports (1..4)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
wen  in  1  writeback write enable
waddr  in  ADDR_WIDTH  write index
wdata  in  DATA_WIDTH  write data
raddr  in  NUM_READ*ADDR_WIDTH  read indices, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
rdata  out  NUM_READ*DATA_WIDTH  read data, port i at bits [i*DATA_WIDTH +: DATA_WIDTH]
rbusy  out  NUM_READ  port i's register has an outstanding producer
set_busy  in  1  decode issued an instruction that writes set_addr
set_addr  in  ADDR_WIDTH  destination index to mark busy
init_done  out  1  clear sequence complete; block accepts writes and busy sets

Behaviour:
- Reset (rst=1 at an edge):
  - Next state is INIT, with clear counter cnt=0.
  - All busy bits are cleared.
  - init_done=0.
  - Asserting rst mid-INIT or mid-RUN restarts INIT from cnt=0.
- INIT state:
  - Each cycle writes 0 to rf[cnt] and increments cnt.
  - The edge that writes rf[DEPTH-1] moves the FSM to RUN; init_done=1 from that edge on.
  - Total latency is DEPTH cycles after rst deasserts (32 with defaults).
  - wen and set_busy are ignored.
  - rdata is all zeros and rbusy is all zeros.
- RUN state: stays in RUN until rst.
- Register 0:
  - Reads always return 0; rbusy is 0.
  - Writes to index 0 and set_busy with set_addr=0 are dropped.
- Write: in RUN with wen=1 and waddr!=0, rf[waddr] <= wdata at the edge.
- Read (combinational, zero latency), evaluated per port i:
  - raddr_i==0 -> 0.
  - else if wen && waddr==raddr_i -> wdata (bypass; applies to every matching port simultaneously).
  - else rf[raddr_i].
- Scoreboard:
  - wen (RUN, waddr!=0) clears busy[waddr].
  - set_busy (RUN, set_addr!=0) sets busy[set_addr].
  - If both target the same index in one cycle, the set wins and the bit ends at 1 (new producer issued).
  - rbusy_i = busy[raddr_i] & ~(wen && waddr==raddr_i) & (raddr_i!=0), so a bypassed value is never reported busy.
  - set_busy on an already-busy index leaves it busy; there is no counting.
- Width rules: no arithmetic on data. cnt is ADDR_WIDTH+1 bits wide so it cannot wrap before the terminal compare.

Decomposition:
- Shared package myCPU_pkg:
  - Constants DATA_WIDTH, ADDR_WIDTH, REG_ZERO=0.
  - FSM state encoding: INIT=1'b0, RUN=1'b1.
- One sub-module, regfile_scoreboard:
  - Holds the DEPTH busy bits, set/clear priority and the rbusy masking.
  - Ports: clk, rst, clr_en, clr_addr, set_en, set_addr, raddr, rbusy.
- The top module holds the storage array, clear FSM and bypass muxes.

Test Plan:
1. Reset and clear: rst high 2 cycles, then low -> init_done=0 for 32 cycles and 1 on cycle 32; a read of any index returns 0x00000000. A wen at cycle 5 of INIT (waddr=3, wdata=0xDEAD) is dropped: after init, r3=0.
2. Basic write/read with NUM_READ=3: write r7=0x12345678, next cycle read ports {7,0,7} -> {0x12345678, 0, 0x12345678}. Write r0=0xFFFFFFFF -> r0 still reads 0.
3. Bypass: r9=0x1 stored; same cycle wen, waddr=9, wdata=0xABCD with raddr port0=9 -> rdata0=0xABCD that cycle, and 0xABCD stays after the edge.
4. Scoreboard: set_busy r4 -> next cycle rbusy=1 for port reading 4. Then wen r4 with a read of 4 in the same cycle -> rbusy=0 and rdata=wdata; busy bit is 0 afterwards.
5. Set/clear collision: busy[6]=1; same cycle wen waddr=6 and set_busy set_addr=6 -> busy[6] stays 1 next cycle. set_busy set_addr=0 -> rbusy for r0 stays 0.
6. Reset mid-run: busy[5]=1 and r5=0x55; assert rst one cycle -> busy cleared and INIT restarts. After 32 cycles r5=0 and init_done=1.
